// File: rtl/median_arbiter.sv
// median_arbiter: round-robin sharing of one 3x3 MEDIAN engine between two pixel requesters.
// Ports: CLK/RST (sync, active-high); REQx/DIx in, GNTx (load window) and DONEx (result pulse) out;
//        DO/ERR result (ERR = watchdog abort); BUSY; M_* drive and observe the MEDIAN engine.
module median_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NPIX    = 9,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] DI0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DI1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic             ERR,
    output logic [WIDTH-1:0] DO,
    output logic             BUSY,
    output logic             M_NRST,
    output logic             M_DSI,
    output logic [WIDTH-1:0] M_DI,
    input  logic [WIDTH-1:0] M_DO,
    input  logic             M_DSO
);
    localparam int CW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CLAST = CW'(NPIX - 1);
    localparam logic [WW-1:0] WLAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    state_t state, next;
    logic sel, last, pick;
    logic [CW-1:0] cnt;
    logic [WW-1:0] wd;

    // On a tie the channel that was not served last wins.
    assign pick = (REQ0 && REQ1) ? ~last : REQ1;

    always_ff @(posedge CLK) state <= RST ? S_IDLE : next;

    always_comb begin
        next = state;
        case (state)
            S_IDLE:  next = (REQ0 || REQ1) ? S_LOAD : S_IDLE;
            S_LOAD:  next = (cnt == CLAST) ? S_WAIT : S_LOAD;
            S_WAIT:  next = (M_DSO || wd == WLAST) ? S_DONE : S_WAIT;
            default: next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sel  <= 1'b0;
            last <= 1'b1;
            cnt  <= '0;
            wd   <= '0;
            DO   <= '0;
            ERR  <= 1'b0;
        end else begin
            if (state == S_IDLE) sel <= pick;
            cnt <= (state == S_LOAD && cnt != CLAST) ? cnt + 1'b1 : '0;
            wd  <= (state == S_WAIT && next == S_WAIT) ? wd + 1'b1 : '0;
            if (state == S_WAIT && M_DSO) begin
                DO  <= M_DO;
                ERR <= 1'b0;
            end else if (state == S_WAIT && wd == WLAST) begin
                DO  <= '0;
                ERR <= 1'b1;
            end
            if (state == S_DONE) last <= sel;
        end
    end

    assign GNT0   = state == S_LOAD && !sel;
    assign GNT1   = state == S_LOAD && sel;
    assign DONE0  = state == S_DONE && !sel;
    assign DONE1  = state == S_DONE && sel;
    assign BUSY   = state != S_IDLE;
    assign M_DSI  = state == S_LOAD;
    assign M_DI   = M_DSI ? (sel ? DI1 : DI0) : '0;
    // Engine is held in reset with RST and flushed for one cycle after a watchdog abort.
    assign M_NRST = !(RST || (state == S_DONE && ERR));
endmodule

// File: tb/tb_median_arbiter.sv
// tb_median_arbiter: scoreboard bench for median_arbiter with a behavioural MEDIAN engine stub.
module tb_median_arbiter;
    logic       clk = 0, rst = 1;
    logic       req0 = 0, req1 = 0;
    logic [7:0] di0 = 0, di1 = 0;
    logic       gnt0, gnt1, done0, done1, err, busy, m_nrst, m_dsi;
    logic [7:0] dout, m_di;
    logic [7:0] m_do = 0;
    logic       m_dso = 0;

    median_arbiter #(.WIDTH(8), .NPIX(9), .TIMEOUT(64)) dut (
        .CLK(clk), .RST(rst), .REQ0(req0), .DI0(di0), .REQ1(req1), .DI1(di1),
        .GNT0(gnt0), .GNT1(gnt1), .DONE0(done0), .DONE1(done1), .ERR(err), .DO(dout),
        .BUSY(busy), .M_NRST(m_nrst), .M_DSI(m_dsi), .M_DI(m_di), .M_DO(m_do), .M_DSO(m_dso)
    );

    always #5 clk = ~clk;

    typedef struct {int ch; int d; int e;} exp_t;
    exp_t q[$];
    int   total = 0, pass = 0, ndone = 0;
    bit   stuck = 0, stray = 0, alt_on = 0;
    int   alt_exp = 0;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got == exp) pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, got, exp);
    endtask

    // Reference median: the value with at most 4 strictly smaller and at least 5 not larger.
    function automatic int ref_med(input logic [7:0] p[9]);
        for (int i = 0; i < 9; i++) begin
            int lt = 0, le = 0;
            for (int j = 0; j < 9; j++) begin
                if (p[j] < p[i]) lt++;
                if (p[j] <= p[i]) le++;
            end
            if (lt <= 4 && le >= 5) return int'(p[i]);
        end
        return -1;
    endfunction

    function automatic logic [7:0] sort_mid(input logic [7:0] b[9]);
        logic [7:0] s[9];
        logic [7:0] t;
        s = b;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (s[j] > s[j+1]) begin
                    t = s[j];
                    s[j] = s[j+1];
                    s[j+1] = t;
                end
        return s[4];
    endfunction

    // MEDIAN engine stub: collects 9 pixels under DSI, answers after 0..3 extra cycles.
    logic [7:0] sbuf[9];
    int  sn = 0, cd = 0;
    bit  pend = 0;
    always @(posedge clk) begin
        m_dso <= 1'b0;
        if (!m_nrst) begin
            sn = 0;
            pend = 0;
        end else if (m_dsi) begin
            sbuf[sn % 9] = m_di;
            sn++;
            if (sn == 9) begin
                sn = 0;
                pend = 1;
                cd = int'($urandom_range(0, 3));
            end
        end else if (pend) begin
            if (cd > 0) cd--;
            else begin
                pend = 0;
                if (!stuck) begin
                    m_dso <= 1'b1;
                    m_do <= sort_mid(sbuf);
                end
            end
        end else if (stray) begin
            m_dso <= 1'($urandom);
            m_do <= 8'($urandom);
        end
    end

    // Monitor: invariants each cycle, scoreboard pop on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (gnt0 || gnt1 || m_dsi) begin
                chk("gnt_exclusive", int'(gnt0 && gnt1), 0);
                chk("dsi_mirrors_gnt", int'(m_dsi), int'(gnt0 || gnt1));
            end
            if (busy && !m_dsi) chk("m_di_zero_outside_load", int'(m_di), 0);
            if (done0 || done1) begin
                ndone++;
                chk("done_exclusive", int'(done0 && done1), 0);
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got DONE0=%0d DONE1=%0d, required none", done0, done1);
                end else begin
                    e = q.pop_front();
                    chk("done_channel", int'(done1), e.ch);
                    chk("result_do", int'(dout), e.d);
                    chk("result_err", int'(err), e.e);
                    chk("m_nrst_at_done", int'(m_nrst), 1 - e.e);
                    if (alt_on) begin
                        chk("alternation", int'(done1), alt_exp);
                        alt_exp = 1 - alt_exp;
                    end
                end
            end
        end
    end

    task automatic set_req(input int ch, input logic v);
        if (ch == 1) req1 = v;
        else req0 = v;
    endtask

    function automatic logic gnt_of(input int ch);
        return (ch == 1) ? gnt1 : gnt0;
    endfunction

    // Request a window, stream its pixels while granted, then post the expected result.
    task automatic send(input int ch, input logic [7:0] p[9], input int to, output int wt);
        exp_t e;
        int n;
        set_req(ch, 1'b1);
        wt = 0;
        while (!gnt_of(ch) && wt < 500) begin
            @(negedge clk);
            wt++;
        end
        set_req(ch, 1'b0);
        if (wt >= 500) begin
            total++;
            $display("FAIL grant_wait ch%0d: got no grant in %0d cycles, required a grant", ch, wt);
            return;
        end
        n = 0;
        while (gnt_of(ch) && n < 12) begin
            if (n < 9) begin
                if (ch == 1) di1 = p[n];
                else di0 = p[n];
            end
            n++;
            @(negedge clk);
        end
        chk("gnt_length", n, 9);
        e.ch = ch;
        e.d  = to ? 0 : ref_med(p);
        e.e  = to;
        q.push_back(e);
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() > 0 || busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            total++;
            $display("FAIL drain: got %0d results outstanding, required 0", q.size());
        end
    endtask

    task automatic rnd(output logic [7:0] p[9]);
        foreach (p[i]) p[i] = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] pa[9], pb[9];
        int wt, c, w, nd, prev;
        pa = '{8'd10, 8'd200, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({gnt0, gnt1, done0, done1, err, busy, m_dsi, m_nrst}), 0);
        chk("reset_do", int'(dout), 0);
        rst = 0;
        @(negedge clk);
        chk("m_nrst_after_reset", int'(m_nrst), 1);

        send(0, pa, 0, wt);
        chk("grant_latency", wt, 1);
        drain();
        chk("single_do_60", int'(dout), 60);

        pb = '{8'd5, 8'd9, 8'd1, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd4};
        send(0, pa, 0, wt);
        fork
            begin
                logic [7:0] pc[9];
                int w2;
                pc = '{8'd100, 8'd90, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20};
                send(1, pc, 0, w2);
            end
            begin
                c = 0;
                while (!done0 && c < 100) begin
                    @(negedge clk);
                    c++;
                end
                c = 0;
                do begin
                    @(negedge clk);
                    c++;
                end while (!gnt1 && c < 50);
                chk("gap_done0_to_gnt1", c, 2);
            end
        join
        drain();
        chk("ch1_result_60", int'(dout), 60);

        req0 = 1;
        c = 0;
        while (!gnt0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        for (int n = 0; n < 4; n++) begin
            di0 = pb[8-n];
            @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        chk("rst_mid_load_outputs", int'({gnt0, gnt1, done0, done1, err, busy, m_dsi, m_nrst}), 0);
        chk("rst_mid_load_do", int'(dout), 0);
        rst = 0;
        nd = ndone;
        send(0, pb, 0, wt);
        drain();
        chk("regrant_single_done", ndone - nd, 1);
        chk("regrant_do", int'(dout), 5);

        stuck = 1;
        send(0, pb, 1, wt);
        w = 0;
        while (!done0 && w < 200) begin
            w++;
            @(negedge clk);
        end
        chk("timeout_wait_cycles", w, 64);
        drain();
        stuck = 0;
        send(1, pa, 0, wt);
        drain();
        chk("after_timeout_do", int'(dout), 60);

        stray = 1;
        prev = int'(dout);
        nd = ndone;
        repeat (40) @(negedge clk);
        chk("stray_no_done", ndone - nd, 0);
        chk("stray_do_hold", int'(dout), prev);
        rnd(pa);
        send(0, pa, 0, wt);
        drain();
        stray = 0;

        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        alt_exp = 0;
        alt_on = 1;
        fork
            begin
                logic [7:0] p0[9];
                int w0;
                for (int i = 0; i < 1000; i++) begin
                    rnd(p0);
                    send(0, p0, 0, w0);
                end
            end
            begin
                logic [7:0] p1[9];
                int w1;
                for (int i = 0; i < 1000; i++) begin
                    rnd(p1);
                    send(1, p1, 0, w1);
                end
            end
        join
        drain();
        alt_on = 0;
        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule

// File: doc/median_arbiter.md
Name: median_arbiter

Overview:
- Shares one MEDIAN 3x3 median engine between two pixel requesters (channel 0, channel 1).
- Grants the engine round-robin and streams the granted requester's 9 pixels into MEDIAN with DSI high.
- Waits for DSO, captures the median and returns it with a per-channel completion pulse.
- Sits between the window-extraction front ends and the single MEDIAN instance. Includes a watchdog against a stuck engine.

Parameters:
- WIDTH, 8, pixel width (matches MEDIAN DI/DO).
- NPIX, 9, pixels per median window.
- TIMEOUT, 64, max cycles in WAIT before abort (>= NPIX).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous active-high reset.
- REQ0  in  1  channel 0 request; hold high until GNT0 rises.
- DI0  in  WIDTH  channel 0 pixel; pixel k is valid in the k-th GNT0 cycle.
- REQ1  in  1  channel 1 request.
- DI1  in  WIDTH  channel 1 pixel.
- GNT0  out  1  high during the 9 load cycles for channel 0.
- GNT1  out  1  high during the 9 load cycles for channel 1.
- DONE0  out  1  one-cycle pulse: channel 0 result valid on DO.
- DONE1  out  1  one-cycle pulse: channel 1 result valid on DO.
- ERR  out  1  valid with a DONEx pulse; 1 = timeout abort.
- DO  out  WIDTH  captured median, held until the next capture.
- BUSY  out  1  state != IDLE.
- M_NRST  out  1  to MEDIAN nRST (active-low).
- M_DSI  out  1  to MEDIAN DSI.
- M_DI  out  WIDTH  to MEDIAN DI.
- M_DO  in  WIDTH  from MEDIAN DO.
- M_DSO  in  1  from MEDIAN DSO.

Behaviour:
- Reset (RST high at posedge):
  - State goes to IDLE; pixel counter, watchdog and DO clear to 0.
  - GNT0/1, DONE0/1, ERR, BUSY and M_DSI are 0.
  - Last-served pointer is set to 1, so channel 0 wins the first tie.
  - M_NRST = 0 while RST is high.
  - Reset mid-LOAD or mid-WAIT aborts silently; no DONE pulse.
- FSM states: IDLE, LOAD, WAIT, DONE.
- IDLE:
  - If any REQ is high, register sel and go to LOAD.
  - Only one request: grant it. Both: grant the channel that is not last-served.
  - No REQ: stay in IDLE.
- LOAD (exactly NPIX cycles, counter 0..NPIX-1):
  - GNT[sel] = 1; M_DSI = 1; M_DI = DI[sel] (combinational mux).
  - Outside LOAD, M_DI = 0.
  - Requester advances its pixel on every cycle GNTx is high.
  - REQ deassert during LOAD is ignored; the load completes.
  - At counter = NPIX-1, go to WAIT.
- WAIT:
  - M_DSI = 0. Watchdog increments each cycle.
  - M_DSO = 1 sampled: DO <= M_DO, ERR <= 0, go to DONE.
  - Watchdog reaches TIMEOUT-1 without M_DSO: DO <= 0, ERR <= 1, go to DONE.
- DONE (1 cycle):
  - DONE[sel] = 1; update last-served <= sel; go to IDLE.
  - If ERR = 1, M_NRST = 0 for this cycle to clear MEDIAN.
- Latency: REQ seen in IDLE at cycle t → GNT high t+1..t+9 → WAIT from t+10 → DONE pulse the cycle after DSO is sampled.
- Minimum gap between grants: 1 IDLE cycle after DONE.
- A request arriving during BUSY waits; it is never dropped while REQ is held.
- DONE0 and DONE1 are never high together. GNT0 and GNT1 are never high together.
- M_DSO outside WAIT is ignored.
- DO width equals WIDTH; no arithmetic beyond counters.
  - Pixel counter width: ceil(log2(NPIX)).
  - Watchdog width: ceil(log2(TIMEOUT)); it must not wrap.

Test Plan:
- Single request: REQ0=1 with pixels 10,200,30,40,50,60,70,80,90 → GNT0 high 9 cycles, M_DSI mirrors GNT0, DONE0 pulse, DO=60, ERR=0, DONE1 never high.
- Simultaneous REQ0/REQ1 after reset → channel 0 served first, then channel 1, then channel 0 again if both are still held (strict alternation); 1000 random windows per channel checked against a software sort.
- REQ1 raised during channel 0 WAIT → GNT1 starts exactly 1 IDLE cycle after DONE0; no pixel loss.
- Stub MEDIAN that never asserts DSO, TIMEOUT=64 → DONEx with ERR=1 and DO=0 exactly 64 cycles into WAIT; M_NRST low for 1 cycle; next request served normally.
- RST pulsed at LOAD cycle 4 → all outputs 0 next cycle, no DONE pulse; a pending REQ0 is regranted from pixel 0 after RST falls.
- REQ0 dropped mid-LOAD → load still runs 9 cycles and DONE0 still pulses; stray M_DSO pulses while IDLE cause no DONE.
